// File: rtl/conv_requant_pkg.sv
// rtl/conv_requant_pkg.sv - shared widths, int8 limits and rounding helpers for conv_requant
package conv_requant_pkg;
  localparam int LANE_W   = 22;
  localparam int LANES    = 6;
  localparam int MULT_W   = 16;
  localparam int OUT_W    = 8;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  // Per-beat settings that ride along with the data through the pipeline.
  typedef struct packed {
    logic [4:0]        shift;
    logic signed [7:0] zp;
    logic              relu;
  } beat_cfg_t;

  localparam beat_cfg_t CFG_DEFAULT = '{shift: 5'd0, zp: 8'sd0, relu: 1'b0};

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                     input logic [4:0] sh);
    if (sh == 5'd0) return p;
    return (p + (64'sd1 <<< (sh - 5'd1))) >>> sh;
  endfunction

  function automatic logic [OUT_W-1:0] clamp_int8(input logic signed [63:0] v);
    if (v > 64'(INT8_MAX)) return OUT_W'(INT8_MAX);
    if (v < 64'(INT8_MIN)) return OUT_W'(INT8_MIN);
    return v[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/conv_requant_fifo.sv
// rtl/conv_requant_fifo.sv - first-word-fall-through sync FIFO with occupancy count
module requant_fifo #(
  parameter int W = 48,
  parameter int D = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [W-1:0]       din_i,
  input  logic               pop_i,
  output logic [W-1:0]       dout_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [$clog2(D):0] count_o
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(D));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - per-lane requantization of accumulator sums to int8 with output FIFO
module conv_requant
  import conv_requant_pkg::*;
#(
  parameter int DW        = LANE_W,
  parameter int DN        = LANES,
  parameter int MW        = MULT_W,
  parameter int FD        = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW*DN-1:0]    s_sum,
  input  logic                s_valid,
  input  logic [MW-1:0]       cfg_mult,
  input  logic [4:0]          cfg_shift,
  input  logic [7:0]          cfg_zp,
  input  logic                cfg_relu,
  input  logic                cfg_load,
  output logic [OUT_W*DN-1:0] o_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                afull,
  output logic                ovf
);
  localparam int PW = DW + MW + 1;
  localparam int RW = PW + 1;
  localparam int CW = $clog2(FD) + 1;

  logic [MW-1:0]         mult_q, mult_d;
  beat_cfg_t             cfg_q, cfg_d;
  beat_cfg_t             s1_cfg_q;
  logic                  s1_v_q, s2_v_q, s3_v_q;
  logic signed [PW-1:0]  s1_p_d [DN];
  logic signed [PW-1:0]  s1_p_q [DN];
  logic signed [RW-1:0]  s2_r_d [DN];
  logic signed [RW-1:0]  s2_r_q [DN];
  logic [OUT_W*DN-1:0]   s3_b_d, s3_b_q;
  logic                  ovf_d, ovf_q;
  logic                  fifo_full, fifo_empty, overflow;
  logic [CW-1:0]         fifo_count;

  always_comb begin
    mult_d = mult_q;
    cfg_d  = cfg_q;
    if (cfg_load) begin
      mult_d = cfg_mult;
      cfg_d  = '{shift: cfg_shift, zp: cfg_zp, relu: cfg_relu};
    end
  end

  for (genvar i = 0; i < DN; i++) begin : g_lane
    logic signed [DW-1:0] sum;
    logic signed [63:0]   r;

    assign sum       = s_sum[i*DW +: DW];
    assign s1_p_d[i] = PW'(sum) * PW'($signed({1'b0, mult_q}));

    always_comb begin
      r = round_shift(64'(s1_p_q[i]), s1_cfg_q.shift);
      if (s1_cfg_q.relu && r < 0) r = '0;
      r = r + 64'($signed(s1_cfg_q.zp));
    end

    assign s2_r_d[i]                    = RW'(r);
    assign s3_b_d[i*OUT_W +: OUT_W]     = clamp_int8(64'(s2_r_q[i]));
  end

  // Overflow is only a loss when the full FIFO is not also draining this edge.
  assign overflow = s3_v_q && fifo_full && !o_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (cfg_load) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_q   <= MW'(1);
      cfg_q    <= CFG_DEFAULT;
      s1_cfg_q <= CFG_DEFAULT;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      s1_p_q   <= '{default: '0};
      s2_r_q   <= '{default: '0};
      s3_b_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mult_q   <= mult_d;
      cfg_q    <= cfg_d;
      s1_cfg_q <= cfg_q;
      s1_v_q   <= s_valid;
      s2_v_q   <= s1_v_q;
      s3_v_q   <= s2_v_q;
      s1_p_q   <= s1_p_d;
      s2_r_q   <= s2_r_d;
      s3_b_q   <= s3_b_d;
      ovf_q    <= ovf_d;
    end
  end

  requant_fifo #(.W(OUT_W*DN), .D(FD)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s3_v_q),
    .din_i   (s3_b_q),
    .pop_i   (o_ready),
    .dout_o  (o_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign o_valid = !fifo_empty;
  assign ovf     = ovf_q;
  assign afull   = (int'(fifo_count) + int'(s1_v_q) + int'(s2_v_q) + int'(s3_v_q))
                   >= (FD - AF_MARGIN);
endmodule
